feature_transfer_writer: RTL and testbench

//   Producer side of the feature-transfer handshake. Accepts per-frame blob features

---
 rtl/feature_transfer_writer_pkg.sv | 15 +
 rtl/feature_transfer_writer_if.sv | 31 +++
 rtl/feature_transfer_writer_fifo.sv | 44 ++++
 rtl/feature_transfer_writer.sv | 150 +++++++++++++++
 tb/tb_feature_transfer_writer.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/feature_transfer_writer_pkg.sv
// Shared types and constants for the feature-transfer writer.
// Imported by the interface, the FIFO and the top.
package feature_transfer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DRAIN,
        DONE
    } state_e;

    localparam int FEATURE_WIDTH = 32;
    localparam int SLOT_STRIDE   = 4;

endpackage

// File: rtl/feature_transfer_writer_if.sv
// Feature input, memory write and frame-report signals of the writer.
// master = the writer itself, slave = its environment.
interface feature_transfer_writer_if;
    import feature_transfer_pkg::*;

    logic                     frameStart;
    logic                     frameEnd;
    logic                     featureValid;
    logic [FEATURE_WIDTH-1:0] featureData;
    logic                     featureReady;
    logic                     memWrite;
    logic [31:0]              memAddress;
    logic [FEATURE_WIDTH-1:0] memData;
    logic                     memAck;
    logic                     dataReady;
    logic [31:0]              numberOfFeatures;
    logic                     overflow;

    modport master (
        input  frameStart, frameEnd, featureValid, featureData, memAck,
        output featureReady, memWrite, memAddress, memData,
        output dataReady, numberOfFeatures, overflow
    );

    modport slave (
        output frameStart, frameEnd, featureValid, featureData, memAck,
        input  featureReady, memWrite, memAddress, memData,
        input  dataReady, numberOfFeatures, overflow
    );

endinterface

// File: rtl/feature_transfer_writer_fifo.sv
// Synchronous FIFO buffering accepted features ahead of the memory writer.
// Pointers carry one extra wrap bit to tell full from empty.
module feature_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q;
    logic [AW:0]      rd_q;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                     (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign data_o  = mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push_i && !full_o)
                wr_q <= wr_q + (AW+1)'(1);
            if (pop_i && !empty_o)
                rd_q <= rd_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (push_i && !full_o)
            mem_q[wr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/feature_transfer_writer.sv
// Collects per-frame features, writes them to the shared buffer and
// reports the stored count with a one-cycle dataReady at frame end.
module feature_transfer_writer
    import feature_transfer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDRESS = 32'h0000_4000,
    parameter int          MAX_FEATURES = 64,
    parameter int          FIFO_DEPTH   = 8
) (
    input logic                        clock,
    input logic                        reset,
    feature_transfer_writer_if.master  bus
);
    localparam int            CW   = $clog2(MAX_FEATURES + 1);
    localparam logic [CW-1:0] MAXC = CW'(MAX_FEATURES);

    state_e                   state_q, state_d;
    logic                     pend_q, pend_d;
    logic [CW-1:0]            acc_q, acc_d;
    logic [CW-1:0]            slot_q, slot_d;
    logic [CW-1:0]            num_q, num_d;
    logic                     ovf_q, ovf_d;
    logic                     rep_ovf_q, rep_ovf_d;
    logic                     wr_q, wr_d;
    logic [31:0]              addr_q, addr_d;
    logic [FEATURE_WIDTH-1:0] data_q, data_d;

    logic                     fifo_full, fifo_empty;
    logic                     accept, push, pop, start;
    logic [FEATURE_WIDTH-1:0] fifo_rdata;

    feature_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FEATURE_WIDTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (bus.featureData),
        .data_o  (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        acc_d     = acc_q;
        slot_d    = slot_q;
        num_d     = num_q;
        ovf_d     = ovf_q;
        rep_ovf_d = rep_ovf_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        data_d    = data_q;

        accept = (state_q == COLLECT) && bus.featureValid && !fifo_full;
        push   = accept && (acc_q < MAXC);
        pop    = ((state_q == COLLECT) || (state_q == DRAIN)) &&
                 !wr_q && !fifo_empty;
        start  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.frameStart) begin
                    state_d = COLLECT;
                    start   = 1'b1;
                end
            end
            COLLECT: begin
                if (bus.frameStart) pend_d = 1'b1;
                if (bus.frameEnd) state_d = DRAIN;
            end
            DRAIN: begin
                if (bus.frameStart) pend_d = 1'b1;
                if (fifo_empty && !wr_q) begin
                    state_d   = DONE;
                    num_d     = slot_q;
                    rep_ovf_d = ovf_q;
                end
            end
            DONE: begin
                pend_d = 1'b0;
                if (pend_q || bus.frameStart) begin
                    state_d = COLLECT;
                    start   = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
        endcase

        // Words past the cap are still consumed so the pipeline never stalls on it
        if (accept) begin
            if (acc_q < MAXC) acc_d = acc_q + CW'(1);
            else              ovf_d = 1'b1;
        end

        if (wr_q && bus.memAck) begin
            wr_d   = 1'b0;
            slot_d = slot_q + CW'(1);
        end else if (pop) begin
            wr_d   = 1'b1;
            addr_d = BASE_ADDRESS + 32'(slot_q) * 32'(SLOT_STRIDE);
            data_d = fifo_rdata;
        end

        if (start) begin
            acc_d  = '0;
            slot_d = '0;
            ovf_d  = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            pend_q    <= 1'b0;
            acc_q     <= '0;
            slot_q    <= '0;
            num_q     <= '0;
            ovf_q     <= 1'b0;
            rep_ovf_q <= 1'b0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            acc_q     <= acc_d;
            slot_q    <= slot_d;
            num_q     <= num_d;
            ovf_q     <= ovf_d;
            rep_ovf_q <= rep_ovf_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
        end
    end

    assign bus.featureReady     = (state_q == COLLECT) && !fifo_full;
    assign bus.memWrite         = wr_q;
    assign bus.memAddress       = addr_q;
    assign bus.memData          = data_q;
    assign bus.dataReady        = (state_q == DONE);
    assign bus.numberOfFeatures = 32'(num_q);
    assign bus.overflow         = rep_ovf_q;

endmodule

// File: tb/tb_feature_transfer_writer.sv
// Bench for feature_transfer_writer: dev0 uses MAX_FEATURES=64,
// dev1 uses MAX_FEATURES=4; expected writes/reports go to queues.
module tb_feature_transfer_writer;

    typedef struct {
        int          d;
        logic [31:0] a;
        logic [31:0] v;
    } wr_t;

    typedef struct {
        int          d;
        logic [31:0] n;
        logic        ov;
    } dn_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        fs[2], fe[2], fv[2], ack[2];
    logic [31:0] fd[2];
    logic        fr[2], mw[2], dr[2], ov[2];
    logic [31:0] ma[2], md[2], nf[2];

    int checks = 0;
    int errors = 0;
    int ack_dly[2], ack_cnt[2], done_cnt[2], exp_done[2];
    int acc_cnt[2], stall_acc[2];

    wr_t wq[$];
    dn_t dq[$];
    wr_t e;
    dn_t f;

    feature_transfer_writer_if ifa();
    feature_transfer_writer_if ifb();

    assign ifa.frameStart   = fs[0];
    assign ifa.frameEnd     = fe[0];
    assign ifa.featureValid = fv[0];
    assign ifa.featureData  = fd[0];
    assign ifa.memAck       = ack[0];
    assign fr[0] = ifa.featureReady;
    assign mw[0] = ifa.memWrite;
    assign ma[0] = ifa.memAddress;
    assign md[0] = ifa.memData;
    assign dr[0] = ifa.dataReady;
    assign nf[0] = ifa.numberOfFeatures;
    assign ov[0] = ifa.overflow;

    assign ifb.frameStart   = fs[1];
    assign ifb.frameEnd     = fe[1];
    assign ifb.featureValid = fv[1];
    assign ifb.featureData  = fd[1];
    assign ifb.memAck       = ack[1];
    assign fr[1] = ifb.featureReady;
    assign mw[1] = ifb.memWrite;
    assign ma[1] = ifb.memAddress;
    assign md[1] = ifb.memData;
    assign dr[1] = ifb.dataReady;
    assign nf[1] = ifb.numberOfFeatures;
    assign ov[1] = ifb.overflow;

    feature_transfer_writer #(
        .BASE_ADDRESS (32'h0000_4000),
        .MAX_FEATURES (64),
        .FIFO_DEPTH   (8)
    ) u_a (
        .clock (clk),
        .reset (rst_n),
        .bus   (ifa)
    );

    feature_transfer_writer #(
        .BASE_ADDRESS (32'h0000_4000),
        .MAX_FEATURES (4),
        .FIFO_DEPTH   (8)
    ) u_b (
        .clock (clk),
        .reset (rst_n),
        .bus   (ifb)
    );

    function automatic void chk(string n, logic [31:0] act,
                                logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", n, act, exp);
        end
    endfunction

    // Memory slave: pulse memAck ack_dly cycles after memWrite rises
    always @(posedge clk) begin
        #2;
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                ack[d] = 1'b0;
                ack_cnt[d] = 0;
            end else if (ack[d]) begin
                ack[d] = 1'b0;
            end else if (mw[d]) begin
                ack_cnt[d]++;
                if (ack_cnt[d] >= ack_dly[d]) begin
                    ack[d] = 1'b1;
                    ack_cnt[d] = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            for (int d = 0; d < 2; d++) begin
                if (mw[d] && ack[d]) begin
                    if (wq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_write: dev%0d addr %h, required none",
                                 d, ma[d]);
                    end else begin
                        e = wq.pop_front();
                        chk("wr_dev", 32'(d), 32'(e.d));
                        chk("wr_addr", ma[d], e.a);
                        chk("wr_data", md[d], e.v);
                    end
                end
                if (dr[d]) begin
                    done_cnt[d]++;
                    if (dq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_dataReady: dev%0d n=%0d, required none",
                                 d, nf[d]);
                    end else begin
                        f = dq.pop_front();
                        chk("dr_dev", 32'(d), 32'(f.d));
                        chk("numberOfFeatures", nf[d], f.n);
                        chk("overflow", 32'(ov[d]), 32'(f.ov));
                    end
                end
                if (fv[d] && fr[d]) acc_cnt[d]++;
                if (fv[d] && !fr[d] && stall_acc[d] < 0)
                    stall_acc[d] = acc_cnt[d];
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int d, input bit is_start);
        if (is_start) fs[d] = 1'b1;
        else          fe[d] = 1'b1;
        tick();
        fs[d] = 1'b0;
        fe[d] = 1'b0;
    endtask

    task automatic send(input int d, input logic [31:0] w);
        int t = 0;
        fv[d] = 1'b1;
        fd[d] = w;
        @(negedge clk);
        while (!fr[d] && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: dev%0d featureReady 0, required 1", d);
        end
        tick();
        fv[d] = 1'b0;
    endtask

    task automatic feats(input int d, input int n, input int maxf,
                         input logic [31:0] seed);
        for (int i = 0; i < n; i++) begin
            if (i < maxf)
                wq.push_back(wr_t'{d, 32'h4000 + 32'(4 * i), seed + 32'(i)});
            send(d, seed + 32'(i));
        end
        dq.push_back(dn_t'{d, 32'(n < maxf ? n : maxf), n > maxf});
        exp_done[d]++;
    endtask

    task automatic frame(input int d, input int n, input int maxf,
                         input logic [31:0] seed);
        pulse(d, 1'b1);
        feats(d, n, maxf, seed);
        pulse(d, 1'b0);
    endtask

    task automatic wait_done(input int d);
        int t = 0;
        while (done_cnt[d] < exp_done[d] && t < 2000) begin
            tick();
            t++;
        end
        chk("dataReady_count", 32'(done_cnt[d]), 32'(exp_done[d]));
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            fs[d] = 0; fe[d] = 0; fv[d] = 0; fd[d] = '0;
            ack_dly[d] = 1; done_cnt[d] = 0; exp_done[d] = 0;
            acc_cnt[d] = 0; stall_acc[d] = 0;
        end
        tick(3);
        for (int d = 0; d < 2; d++) begin
            chk("rst_memWrite", 32'(mw[d]), 0);
            chk("rst_dataReady", 32'(dr[d]), 0);
            chk("rst_featureReady", 32'(fr[d]), 0);
            chk("rst_numberOfFeatures", nf[d], 0);
        end
        rst_n = 1'b1;
        tick(2);

        // Three features, x = 1..3, y = 10
        frame(0, 3, 64, 32'h000A_0001);
        wait_done(0);
        tick(2);

        // Empty frame
        frame(0, 0, 64, 32'h0);
        wait_done(0);
        tick(2);

        // Cap of 4 on dev1, then a normal frame clears overflow
        frame(1, 6, 4, 32'h0020_0011);
        wait_done(1);
        tick(2);
        frame(1, 2, 4, 32'h0030_0021);
        wait_done(1);
        tick(2);

        // Slow memory: FIFO fills and backpressures, nothing is lost
        ack_dly[0] = 20;
        acc_cnt[0] = 0;
        stall_acc[0] = -1;
        frame(0, 12, 64, 32'h0040_0100);
        wait_done(0);
        chk("accepted_12", 32'(acc_cnt[0]), 12);
        chk("stall_near_8_buffered",
            32'(stall_acc[0] >= 8 && stall_acc[0] <= 9), 1);
        tick(2);

        // frameStart while draining starts the next frame after DONE
        ack_dly[0] = 5;
        pulse(0, 1'b1);
        feats(0, 3, 64, 32'h0050_0001);
        pulse(0, 1'b0);
        pulse(0, 1'b1);
        feats(0, 2, 64, 32'h0060_0001);
        pulse(0, 1'b0);
        wait_done(0);
        tick(2);

        // Reset during an outstanding write
        ack_dly[0] = 100;
        pulse(0, 1'b1);
        send(0, 32'hDEAD_0001);
        for (int t = 0; t < 50 && !mw[0]; t++) tick();
        chk("pre_rst_memWrite", 32'(mw[0]), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_memWrite", 32'(mw[0]), 0);
        chk("arst_memAddress", ma[0], 0);
        chk("arst_memData", md[0], 0);
        chk("arst_dataReady", 32'(dr[0]), 0);
        chk("arst_numberOfFeatures", nf[0], 0);
        chk("arst_featureReady", 32'(fr[0]), 0);
        tick(3);
        rst_n = 1'b1;
        ack_dly[0] = 1;
        tick(2);
        frame(0, 1, 64, 32'h0070_0009);
        wait_done(0);
        tick(5);

        chk("writes_left", 32'(wq.size()), 0);
        chk("reports_left", 32'(dq.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
